lift_request_scheduler: RTL and testbench
=========================================

Name: lift_request_scheduler

Overview:
Per-car sequencing controller for the lift datapath. Latches hall-up, hall-down and in-car floor requests. Runs a SCAN (collective) policy to choose travel direction, times floor-to-floor travel and door dwell, and clears requests as they are served. Drives the floor, direction and motion signals that feed the 7-segment/arrow display logic.

Parameters:
N_FLOORS, 4, number of floors (>=2); floor 0 = bottom.
FLOOR_W, $clog2(N_FLOORS) (min 1), width of floor index.
TRAVEL_CYCLES, 4, clock cycles to travel one floor (>=1).
DOOR_CYCLES, 3, clock cycles door stays open (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
hall_up_req  in  N_FLOORS  level/pulse hall-up calls; bit N_FLOORS-1 ignored
hall_dn_req  in  N_FLOORS  hall-down calls; bit 0 ignored
car_req  in  N_FLOORS  in-car floor buttons
current_floor  out  FLOOR_W  registered floor index
direction  out  2  00 idle, 01 up, 10 down
moving  out  1  high in MOVE state
door_open  out  1  high in DOOR state
pending  out  N_FLOORS  OR of all three pending vectors, for lamps

Behaviour:
- Reset (one clk edge with rst=1, also mid-operation): state IDLE; current_floor=0; direction=00; moving=0; door_open=0; all pending vectors cleared; timer=0.
- Request latch: at each edge, pend_x |= req_x & mask. Masks drop hall_up[top] and hall_dn[0]. A request sampled at edge k is visible in pending after edge k. Latched requests are never cancelled.
- Terms (combinational): at_here = any pending at current_floor; above = any pending > floor; below = any pending < floor.
- IDLE:
  - at_here -> DOOR; clear all three bits at current floor.
  - else if above and not (direction==10 and below) -> MOVE, direction=01.
  - else if below -> MOVE, direction=10.
  - else direction=00.
  - With no previous direction, above beats below.
- MOVE: timer loads TRAVEL_CYCLES-1 on entry and decrements each cycle. At timer==0, floor +/-1 and go to ARRIVE. Floor never leaves [0, N_FLOORS-1].
- ARRIVE (1 cycle), stop if any of:
  - car bit at this floor;
  - same-direction hall bit at this floor;
  - nothing pending further ahead.
- On stop:
  - clear car bit and same-direction hall bit;
  - if nothing pending ahead, also clear opposite hall bit and set direction to the reverse (or 00 if nothing pending anywhere);
  - go to DOOR.
- If no stop: MOVE, timer reloaded.
- DOOR: door_open=1 for exactly DOOR_CYCLES cycles, then IDLE. IDLE keeps direction as SCAN preference.
  - A request for current_floor that matches the served set (car, or hall in current direction) during DOOR is absorbed (not latched) and restarts the timer.
  - The same absorb rule covers a request arriving in the same cycle its bit is cleared.
- Latency: IDLE -> MOVE one edge after the request is latched. One floor = TRAVEL_CYCLES+1 cycles including ARRIVE.
- moving=1 only in MOVE/ARRIVE. door_open and moving are never both 1.

Optional Feature:
LIFT_FIRE_RECALL_EN
- Defined:
  - Adds input port fire_recall (1 bit).
  - While high: all pending vectors are cleared and request inputs are ignored; the car is sent to floor 0 with direction=10.
  - A car in DOOR closes immediately.
  - At floor 0 the car holds DOOR with door_open=1 until fire_recall deasserts, then goes to IDLE with direction=00.
  - A car in MOVE upward completes the current floor segment, then reverses.
- Undefined: no port; behaviour as above.

Decomposition:
- Package lift_pkg holds:
  - state enum (IDLE, MOVE, ARRIVE, DOOR);
  - direction constants DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DN=2'b10.
- Sub-module lift_dwell_timer: loadable down-counter with load value input, load strobe and zero flag. Shared by travel and door timing.

Test Plan (N_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3):
1. Assert rst for 2 cycles mid-MOVE at floor 2 -> next cycle floor=0, direction=00, moving=0, door_open=0, pending=0.
2. Idle at 0, pulse car_req[2] -> direction=01, moving=1, floor=1, no stop at floor 1; floor=2 exactly 10 cycles after MOVE entry; door_open for 3 cycles; then direction=00, pending=0.
3. Car heading to car_req[3]; before reaching floor 2, latch hall_up[2] and hall_dn[1] -> stops at 2 up, passes 1, stops at 3; reverses with direction=10 and stops at 1; hall_dn[1] cleared there.
4. Idle at floor 0, pulse hall_up[0] -> door_open next cycle, moving never asserts, pending[0] clears.
5. Pulse hall_dn[0] and hall_up[3] while idle -> ignored; pending stays 0, direction=00.
6. During DOOR at floor 2 going up, pulse car_req[2] -> door timer restarts, door_open lasts 3 cycles after the pulse, pending[2] stays 0.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types and constants for the lift request scheduler.
//   lift_state_e : controller state (idle, moving between floors, arrival decision, door open)
//   DIR_*        : encoding of the direction output
package lift_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMove,
    StArrive,
    StDoor
  } lift_state_e;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

endpackage

// File: rtl/lift_dwell_timer.sv
// Loadable down-counter used for both floor travel time and door dwell time.
//   clk, rst  : clock and synchronous active-high reset
//   load      : load strobe, takes priority over counting
//   load_val  : value loaded on the strobe
//   zero      : high while the count is zero; the counter holds at zero
module lift_dwell_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lift_request_scheduler.sv
// Per-car SCAN (collective) scheduler: latches hall and car calls, picks the travel direction,
// times travel and door dwell, and clears calls as floors are served.
//   clk, rst             : clock, synchronous active-high reset
//   hall_up_req          : hall-up calls (top floor bit ignored)
//   hall_dn_req          : hall-down calls (bottom floor bit ignored)
//   car_req              : in-car floor buttons
//   current_floor        : registered floor index
//   direction            : 00 idle, 01 up, 10 down
//   moving / door_open   : registered state flags, never both high
//   pending              : OR of all latched calls, for lamps
// Optional feature, enabled by defining LIFT_FIRE_RECALL_EN: adds input fire_recall, which
// discards all calls and sends the car to floor 0, holding the door open there until release.
module lift_request_scheduler
  import lift_pkg::*;
#(
  parameter int unsigned N_FLOORS      = 4,
  parameter int unsigned FLOOR_W       = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic                clk,
  input  logic                rst,
`ifdef LIFT_FIRE_RECALL_EN
  input  logic                fire_recall,
`endif
  input  logic [N_FLOORS-1:0] hall_up_req,
  input  logic [N_FLOORS-1:0] hall_dn_req,
  input  logic [N_FLOORS-1:0] car_req,
  output logic [FLOOR_W-1:0]  current_floor,
  output logic [1:0]          direction,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);

  localparam int unsigned TimerMax = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0]   TravelLoad = TimerW'(TRAVEL_CYCLES - 1);
  localparam logic [TimerW-1:0]   DoorLoad   = TimerW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]  TopFloor   = FLOOR_W'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] UpMask     = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DnMask     = {{(N_FLOORS-1){1'b1}}, 1'b0};

  lift_state_e         state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d, floor_step;
  logic [1:0]          dir_q, dir_d;
  logic [N_FLOORS-1:0] pend_up_q, pend_up_d, pend_dn_q, pend_dn_d, pend_car_q, pend_car_d;
  logic [N_FLOORS-1:0] up_in, dn_in, car_in, all_pend, here_vec;
  logic [N_FLOORS-1:0] clr_up, clr_dn, clr_car;
  logic                moving_q, door_open_q;
  logic                at_here, above, below, ahead, behind;
  logic                car_here, same_here, absorb, req_en;
  logic                tmr_load, tmr_zero;
  logic [TimerW-1:0]   tmr_val;
`ifdef LIFT_FIRE_RECALL_EN
  logic                recall_hold_q, recall_hold_d;

  assign req_en = ~fire_recall;
`else
  assign req_en = 1'b1;
`endif

  assign up_in    = hall_up_req & UpMask & {N_FLOORS{req_en}};
  assign dn_in    = hall_dn_req & DnMask & {N_FLOORS{req_en}};
  assign car_in   = car_req & {N_FLOORS{req_en}};
  assign all_pend = pend_up_q | pend_dn_q | pend_car_q;
  assign here_vec = {{(N_FLOORS-1){1'b0}}, 1'b1} << floor_q;

  always_comb begin
    at_here = 1'b0;
    above   = 1'b0;
    below   = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (all_pend[i]) begin
        if (i == 32'(floor_q))     at_here = 1'b1;
        else if (i > 32'(floor_q)) above   = 1'b1;
        else                       below   = 1'b1;
      end
    end
  end

  assign ahead     = (dir_q == DIR_DN) ? below : above;
  assign behind    = (dir_q == DIR_DN) ? above : below;
  assign car_here  = |(pend_car_q & here_vec);
  assign same_here = (dir_q == DIR_UP) ? |(pend_up_q & here_vec) : |(pend_dn_q & here_vec);
  assign absorb    = |(car_in & here_vec) ||
                     ((dir_q == DIR_UP) && |(up_in & here_vec)) ||
                     ((dir_q == DIR_DN) && |(dn_in & here_vec));

  // Saturating step keeps the floor index inside the shaft.
  always_comb begin
    floor_step = floor_q;
    if (dir_q == DIR_DN) begin
      if (floor_q != '0) floor_step = floor_q - FLOOR_W'(1);
    end else if (floor_q != TopFloor) begin
      floor_step = floor_q + FLOOR_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    tmr_val  = TravelLoad;
    clr_up   = '0;
    clr_dn   = '0;
    clr_car  = '0;
    unique case (state_q)
      StIdle: begin
        if (at_here) begin
          state_d  = StDoor;
          clr_up   = here_vec;
          clr_dn   = here_vec;
          clr_car  = here_vec;
          tmr_load = 1'b1;
          tmr_val  = DoorLoad;
        end else if (above && !(dir_q == DIR_DN && below)) begin
          state_d  = StMove;
          dir_d    = DIR_UP;
          tmr_load = 1'b1;
        end else if (below) begin
          state_d  = StMove;
          dir_d    = DIR_DN;
          tmr_load = 1'b1;
        end else begin
          dir_d = DIR_IDLE;
        end
      end
      StMove: begin
        if (tmr_zero) begin
          floor_d = floor_step;
          state_d = StArrive;
        end
      end
      StArrive: begin
        if (car_here || same_here || !ahead) begin
          clr_car = here_vec;
          if (dir_q == DIR_UP) clr_up = here_vec;
          else                 clr_dn = here_vec;
          // End of the sweep: serve both hall calls here and turn round if anything is left.
          if (!ahead) begin
            clr_up = here_vec;
            clr_dn = here_vec;
            if (behind) dir_d = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
            else        dir_d = DIR_IDLE;
          end
          state_d  = StDoor;
          tmr_load = 1'b1;
          tmr_val  = DoorLoad;
        end else begin
          state_d  = StMove;
          tmr_load = 1'b1;
        end
      end
      StDoor: begin
        // Calls already being served here are swallowed and just hold the door open longer.
        clr_car = here_vec;
        if (dir_q == DIR_UP)      clr_up = here_vec;
        else if (dir_q == DIR_DN) clr_dn = here_vec;
        if (absorb) begin
          tmr_load = 1'b1;
          tmr_val  = DoorLoad;
        end else if (tmr_zero) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef LIFT_FIRE_RECALL_EN
    recall_hold_d = recall_hold_q;
    if (fire_recall) begin
      state_d  = state_q;
      floor_d  = floor_q;
      dir_d    = DIR_DN;
      tmr_load = 1'b0;
      tmr_val  = TravelLoad;
      if (state_q == StMove) begin
        // Finish the segment in progress; the turn happens at the next arrival.
        dir_d = dir_q;
        if (tmr_zero) begin
          floor_d = floor_step;
          state_d = StArrive;
        end
      end else if (floor_q == '0) begin
        state_d       = StDoor;
        recall_hold_d = 1'b1;
      end else begin
        state_d  = StMove;
        tmr_load = 1'b1;
      end
    end else if (recall_hold_q) begin
      state_d       = StIdle;
      dir_d         = DIR_IDLE;
      tmr_load      = 1'b0;
      recall_hold_d = 1'b0;
    end
`endif
  end

  // Clearing wins over a same-cycle request for the same bit.
  assign pend_up_d  = (pend_up_q | up_in) & ~clr_up & {N_FLOORS{req_en}};
  assign pend_dn_d  = (pend_dn_q | dn_in) & ~clr_dn & {N_FLOORS{req_en}};
  assign pend_car_d = (pend_car_q | car_in) & ~clr_car & {N_FLOORS{req_en}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      floor_q     <= '0;
      dir_q       <= DIR_IDLE;
      pend_up_q   <= '0;
      pend_dn_q   <= '0;
      pend_car_q  <= '0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      pend_up_q   <= pend_up_d;
      pend_dn_q   <= pend_dn_d;
      pend_car_q  <= pend_car_d;
      moving_q    <= (state_d == StMove) || (state_d == StArrive);
      door_open_q <= (state_d == StDoor);
    end
  end

`ifdef LIFT_FIRE_RECALL_EN
  always_ff @(posedge clk) begin
    if (rst) recall_hold_q <= 1'b0;
    else     recall_hold_q <= recall_hold_d;
  end
`endif

  lift_dwell_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign moving        = moving_q;
  assign door_open     = door_open_q;
  assign pending       = all_pend;

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Self-checking bench for lift_request_scheduler (4 floors, travel 4, door 3).
module tb_lift_request_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       fire_recall;
  logic [3:0] hall_up_req, hall_dn_req, car_req;
  logic [1:0] current_floor, direction;
  logic       moving, door_open;
  logic [3:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lift_request_scheduler #(
    .N_FLOORS     (4),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
`ifdef LIFT_FIRE_RECALL_EN
    .fire_recall  (fire_recall),
`endif
    .clk          (clk),
    .rst          (rst),
    .hall_up_req  (hall_up_req),
    .hall_dn_req  (hall_dn_req),
    .car_req      (car_req),
    .current_floor(current_floor),
    .direction    (direction),
    .moving       (moving),
    .door_open    (door_open),
    .pending      (pending)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] up, dn, car;
    logic [1:0] floor, dir;
    logic       mv, door;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic r, input logic [3:0] u,
                              input logic [3:0] d, input logic [3:0] c, input logic [1:0] f,
                              input logic [1:0] dr, input logic m, input logic o,
                              input logic [3:0] p);
    vec_t v;
    v.name = n; v.rst = r; v.up = u; v.dn = d; v.car = c;
    v.floor = f; v.dir = dr; v.mv = m; v.door = o; v.pend = p;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("moving_and_door_exclusive", 32'(moving & door_open), 32'd0);
  endtask

  task automatic check_outputs(input string name, input logic [1:0] f, input logic [1:0] dr,
                               input logic m, input logic o, input logic [3:0] p);
    check({name, ".floor"}, 32'(current_floor), 32'(f));
    check({name, ".dir"}, 32'(direction), 32'(dr));
    check({name, ".moving"}, 32'(moving), 32'(m));
    check({name, ".door"}, 32'(door_open), 32'(o));
    check({name, ".pending"}, 32'(pending), 32'(p));
  endtask

  // Waits until the car is at floor f with the door open (want_door) or moving.
  task automatic wait_at(input logic [1:0] f, input logic want_door, input int budget,
                         input string name);
    for (int i = 0; i < budget; i++) begin
      if (current_floor == f && (want_door ? door_open : moving)) break;
      tick();
    end
    n_checks++;
    if (current_floor == f && (want_door ? door_open : moving)) n_pass++;
    else $display("FAIL %s: timeout, floor=%0d door=%0b moving=%0b", name, current_floor,
                  door_open, moving);
  endtask

  logic [1:0] stop_floor[3];
  logic [1:0] stop_dir[3];
  logic [3:0] stop_pend[3];
  logic [1:0] exp_floor[3];
  logic [1:0] exp_dir[3];
  logic [3:0] exp_pend[3];
  int         n_stops;
  logic       prev_door;

  initial begin
    rst = 1'b1; fire_recall = 1'b0;
    hall_up_req = '0; hall_dn_req = '0; car_req = '0;

    // Reset, hall call at the parked floor, masked calls, single car call two floors up.
    add("rst_a",      1, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 4'h0);
    add("rst_b",      1, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 4'h0);
    add("hu0_latch",  0, 4'h1, 4'h0, 4'h0, 0, 2'b00, 0, 0, 4'h1);
    for (int k = 0; k < 3; k++) add("hu0_door", 0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0, 1, 4'h0);
    add("hu0_closed", 0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 4'h0);
    add("masked",     0, 4'h8, 4'h1, 4'h0, 0, 2'b00, 0, 0, 4'h0);
    add("masked_hold",0, 4'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 4'h0);
    add("c2_latch",   0, 4'h0, 4'h0, 4'h4, 0, 2'b00, 0, 0, 4'h4);
    for (int k = 0; k < 4; k++) add("c2_move_f0", 0, 4'h0, 4'h0, 4'h0, 0, 2'b01, 1, 0, 4'h4);
    for (int k = 0; k < 5; k++) add("c2_pass_f1", 0, 4'h0, 4'h0, 4'h0, 1, 2'b01, 1, 0, 4'h4);
    add("c2_arrive_f2", 0, 4'h0, 4'h0, 4'h0, 2, 2'b01, 1, 0, 4'h4);
    for (int k = 0; k < 3; k++) add("c2_door", 0, 4'h0, 4'h0, 4'h0, 2, 2'b00, 0, 1, 4'h0);
    add("c2_closed",  0, 4'h0, 4'h0, 4'h0, 2, 2'b00, 0, 0, 4'h0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      hall_up_req = vecs[i].up; hall_dn_req = vecs[i].dn; car_req = vecs[i].car;
      tick();
      check_outputs($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].floor, vecs[i].dir,
                    vecs[i].mv, vecs[i].door, vecs[i].pend);
    end
    hall_up_req = '0; hall_dn_req = '0; car_req = '0;

    // Sweep up to car call 3 with hall calls picked up / skipped on the way, then back down.
    rst = 1'b1; tick(); rst = 1'b0;
    car_req = 4'h8; tick(); car_req = '0;
    tick();
    hall_up_req = 4'h4; hall_dn_req = 4'h2; tick();
    hall_up_req = '0; hall_dn_req = '0;
    check("t3_latched", 32'(pending), 32'h0000_000e);
    exp_floor = '{2'd2, 2'd3, 2'd1};
    exp_dir   = '{2'b01, 2'b10, 2'b00};
    exp_pend  = '{4'ha, 4'h2, 4'h0};
    n_stops = 0;
    prev_door = door_open;
    for (int i = 0; i < 200 && n_stops < 3; i++) begin
      tick();
      if (door_open && !prev_door) begin
        stop_floor[n_stops] = current_floor;
        stop_dir[n_stops]   = direction;
        stop_pend[n_stops]  = pending;
        n_stops++;
      end
      prev_door = door_open;
    end
    check("t3_stop_count", 32'(n_stops), 32'd3);
    for (int k = 0; k < n_stops; k++) begin
      check($sformatf("t3_stop%0d.floor", k), 32'(stop_floor[k]), 32'(exp_floor[k]));
      check($sformatf("t3_stop%0d.dir", k), 32'(stop_dir[k]), 32'(exp_dir[k]));
      check($sformatf("t3_stop%0d.pending", k), 32'(stop_pend[k]), 32'(exp_pend[k]));
    end

    // Reset while travelling at floor 2.
    car_req = 4'h8; tick(); car_req = '0;
    wait_at(2'd2, 1'b0, 100, "t1_reach_f2");
    check("t1_pending_before", 32'(pending), 32'h8);
    rst = 1'b1;
    tick(); check_outputs("t1_rst1", 0, 2'b00, 0, 0, 4'h0);
    tick(); check_outputs("t1_rst2", 0, 2'b00, 0, 0, 4'h0);
    rst = 1'b0;
    tick(); check_outputs("t1_after", 0, 2'b00, 0, 0, 4'h0);

    // Car call for the open floor during an upward stop restarts the dwell.
    car_req = 4'h8; hall_up_req = 4'h4; tick();
    car_req = '0; hall_up_req = '0;
    wait_at(2'd2, 1'b1, 100, "t6_door_f2");
    check("t6_dir_up", 32'(direction), 32'h1);
    check("t6_pending_at_open", 32'(pending), 32'h8);
    tick();
    car_req = 4'h4; tick(); car_req = '0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t6_door_held%0d", k), 32'(door_open), 32'd1);
      check($sformatf("t6_pending%0d", k), 32'(pending), 32'h8);
      if (k < 2) tick();
    end
    tick();
    check("t6_door_closed", 32'(door_open), 32'd0);
    wait_at(2'd3, 1'b1, 100, "t6_door_f3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
